// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width and op-code encoding.
package alu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_NOR = 4'b0011,
    OP_ADD = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SRL = 4'b1000,
    OP_SLL = 4'b1001,
    OP_SRA = 4'b1010
  } op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage driver and the ALU.
interface alu_if import alu_pkg::*; #(
  parameter int W = WIDTH
);
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [3:0]   op_code;
  logic [W-1:0] Z;
  logic         overflow;
  logic         equal;
  logic         zero;

  modport master (output X, Y, op_code, input Z, overflow, equal, zero);
  modport slave  (input X, Y, op_code, output Z, overflow, equal, zero);
endinterface

// File: rtl/alu_shifter.sv
// Combinational log-depth barrel shifter for SRL/SLL/SRA; outputs 0 for any other op.
module alu_shifter import alu_pkg::*; #(
  parameter int W  = WIDTH,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  x_i,
  input  logic [SW-1:0] shamt_i,
  input  op_e           op_i,
  output logic [W-1:0]  result_o
);

  logic          left;
  logic          fill;
  logic [W-1:0]  x_rev;
  logic [W-1:0]  out_rev;
  logic [W-1:0]  stage [SW+1];

  assign left = (op_i == OP_SLL);
  assign fill = (op_i == OP_SRA) & x_i[W-1];

  // Left shifts reuse the right-shift ladder on the bit-reversed operand.
  for (genvar gi = 0; gi < W; gi++) begin : g_rev
    assign x_rev[gi]   = x_i[W-1-gi];
    assign out_rev[gi] = stage[SW][W-1-gi];
  end

  assign stage[0] = left ? x_rev : x_i;

  for (genvar gi = 0; gi < SW; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    assign stage[gi+1] = shamt_i[gi] ? {{SH{fill}}, stage[gi][W-1:SH]} : stage[gi];
  end

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_SRL, OP_SRA: result_o = stage[SW];
      OP_SLL:         result_o = out_rev;
      default:        result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: logic, add/sub, signed SLT and shifts with overflow/equal/zero flags.
module alu import alu_pkg::*; #(
  parameter int W = WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus_if
);

  localparam int SW = $clog2(W);

  op_e          op;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] shift_res;
  logic         add_ovf;
  logic         sub_ovf;
  logic         slt;

  logic [W-1:0] z_d, z_q;
  logic         ovf_d, ovf_q;
  logic         equal_d, equal_q;
  logic         zero_d, zero_q;

  assign op   = op_e'(bus_if.op_code);
  assign sum  = bus_if.X + bus_if.Y;
  assign diff = bus_if.X - bus_if.Y;

  assign add_ovf = (bus_if.X[W-1] == bus_if.Y[W-1]) && (sum[W-1] != bus_if.X[W-1]);
  assign sub_ovf = (bus_if.X[W-1] != bus_if.Y[W-1]) && (diff[W-1] != bus_if.X[W-1]);
  // Differing signs decide the compare directly, so a wrapped difference is never trusted.
  assign slt = (bus_if.X[W-1] != bus_if.Y[W-1]) ? bus_if.X[W-1] : diff[W-1];

  alu_shifter #(.W(W), .SW(SW)) u_shifter (
    .x_i      (bus_if.X),
    .shamt_i  (bus_if.Y[SW-1:0]),
    .op_i     (op),
    .result_o (shift_res)
  );

  always_comb begin
    z_d   = '0;
    ovf_d = 1'b0;
    case (op)
      OP_AND: z_d = bus_if.X & bus_if.Y;
      OP_OR:  z_d = bus_if.X | bus_if.Y;
      OP_XOR: z_d = bus_if.X ^ bus_if.Y;
      OP_NOR: z_d = ~(bus_if.X | bus_if.Y);
      OP_ADD: begin
        z_d   = sum;
        ovf_d = add_ovf;
      end
      OP_SUB: begin
        z_d   = diff;
        ovf_d = sub_ovf;
      end
      OP_SLT: z_d = {{(W-1){1'b0}}, slt};
      OP_SRL, OP_SLL, OP_SRA: z_d = shift_res;
      default: z_d = '0;
    endcase
    equal_d = (bus_if.X == bus_if.Y);
    zero_d  = (z_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q     <= '0;
      ovf_q   <= 1'b0;
      equal_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      equal_q <= equal_d;
      zero_q  <= zero_d;
    end
  end

  assign bus_if.Z        = z_q;
  assign bus_if.overflow = ovf_q;
  assign bus_if.equal    = equal_q;
  assign bus_if.zero     = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal vectors, randomized ops and async reset checks.
module tb_alu;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] m_z    = '0;
  logic        m_ovf  = 1'b0;
  logic        m_eq   = 1'b0;
  logic        m_zero = 1'b1;

  alu_if bus ();

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on sign-extended 64-bit values.
  function automatic logic [31:0] ref_z(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] op);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint r;
    int     sh = int'(y[4:0]);
    logic [31:0] z = '0;
    case (op)
      4'd0: z = x & y;
      4'd1: z = x | y;
      4'd2: z = x ^ y;
      4'd3: z = ~(x | y);
      4'd5: begin r = sx + sy; z = r[31:0]; end
      4'd6: begin r = sx - sy; z = r[31:0]; end
      4'd7: z = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: z = x >> sh;
      4'd9: z = x << sh;
      4'd10: z = 32'($signed(x) >>> sh);
      default: z = '0;
    endcase
    return z;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] op);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint r;
    if (op == 4'd5) begin
      r = sx + sy;
      return (r > MAXS) || (r < MINS);
    end
    if (op == 4'd6) begin
      r = sx - sy;
      return (r > MAXS) || (r < MINS);
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_z    <= '0;
      m_ovf  <= 1'b0;
      m_eq   <= 1'b0;
      m_zero <= 1'b1;
    end else begin
      m_z    <= ref_z(bus.X, bus.Y, bus.op_code);
      m_ovf  <= ref_ovf(bus.X, bus.Y, bus.op_code);
      m_eq   <= (bus.X == bus.Y);
      m_zero <= (ref_z(bus.X, bus.Y, bus.op_code) == 32'd0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_Z",   bus.Z, m_z);
      chk("cyc_ovf", {31'd0, bus.overflow}, {31'd0, m_ovf});
      chk("cyc_eq",  {31'd0, bus.equal},    {31'd0, m_eq});
      chk("cyc_zero",{31'd0, bus.zero},     {31'd0, m_zero});
    end
  end

  task automatic dcheck(input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] op, input logic [31:0] ez, input logic eovf);
    @(negedge clk);
    bus.X = x;
    bus.Y = y;
    bus.op_code = op;
    @(posedge clk);
    #1;
    chk($sformatf("%s op%0d Z", nm, op), bus.Z, ez);
    chk($sformatf("%s op%0d ovf", nm, op), {31'd0, bus.overflow}, {31'd0, eovf});
    chk($sformatf("%s op%0d eq", nm, op), {31'd0, bus.equal}, {31'd0, x == y});
    chk($sformatf("%s op%0d zero", nm, op), {31'd0, bus.zero}, {31'd0, ez == 32'd0});
    chk($sformatf("%s op%0d model", nm, op), m_z, ez);
    $display("[TB] %s X=%08h Y=%08h op=%0d -> Z=%08h ovf=%0b eq=%0b zero=%0b",
             nm, x, y, op, bus.Z, bus.overflow, bus.equal, bus.zero);
  endtask

  initial begin
    logic [31:0] rx, ry;
    bus.X = '0;
    bus.Y = '0;
    bus.op_code = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Z",    bus.Z, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd1);
    chk("rst_eq",   {31'd0, bus.equal}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.overflow}, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int op = 0; op <= 10; op++)
      dcheck("zeros", 32'h0, 32'h0, 4'(op), (op == 3) ? 32'hffffffff : 32'h0, 1'b0);

    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd5,  32'h00000001, 1'b0);
    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd6,  32'hfffffffd, 1'b0);
    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd7,  32'h00000001, 1'b0);
    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd8,  32'h3fffffff, 1'b0);
    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd9,  32'hfffffffc, 1'b0);
    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd10, 32'hffffffff, 1'b0);
    dcheck("neg1_2", 32'hffffffff, 32'h2, 4'd3,  32'h00000000, 1'b0);

    dcheck("min_m1", 32'h80000000, 32'hffffffff, 4'd5,  32'h7fffffff, 1'b1);
    dcheck("min_m1", 32'h80000000, 32'hffffffff, 4'd6,  32'h80000001, 1'b0);
    dcheck("min_m1", 32'h80000000, 32'hffffffff, 4'd7,  32'h00000001, 1'b0);
    dcheck("min_m1", 32'h80000000, 32'hffffffff, 4'd10, 32'hffffffff, 1'b0);
    dcheck("min_m1", 32'h80000000, 32'hffffffff, 4'd8,  32'h00000001, 1'b0);

    dcheck("same", 32'h44906a28, 32'h44906a28, 4'd5, 32'h8920d450, 1'b1);
    dcheck("same", 32'h44906a28, 32'h44906a28, 4'd6, 32'h00000000, 1'b0);
    dcheck("same", 32'h44906a28, 32'h44906a28, 4'd7, 32'h00000000, 1'b0);
    dcheck("same", 32'h44906a28, 32'h44906a28, 4'd2, 32'h00000000, 1'b0);
    dcheck("same", 32'h44906a28, 32'h44906a28, 4'd13, 32'h00000000, 1'b0);

    dcheck("one_max", 32'h1, 32'h7fffffff, 4'd5,  32'h80000000, 1'b1);
    dcheck("one_max", 32'h1, 32'h7fffffff, 4'd9,  32'h80000000, 1'b0);
    dcheck("one_max", 32'h1, 32'h7fffffff, 4'd10, 32'h00000000, 1'b0);
    dcheck("one_max", 32'h1, 32'h7fffffff, 4'd7,  32'h00000001, 1'b0);
    dcheck("sh0", 32'h9abc0123, 32'hffffffe0, 4'd10, 32'h9abc0123, 1'b0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 5))
        0: rx = 32'h80000000;
        1: rx = 32'h7fffffff;
        2: rx = 32'hffffffff;
        default: rx = $urandom;
      endcase
      ry = ($urandom_range(0, 3) == 0) ? rx : $urandom;
      bus.X = rx;
      bus.Y = ry;
      bus.op_code = 4'($urandom_range(0, 15));
      $display("[TB] rand X=%08h Y=%08h op=%0d", rx, ry, bus.op_code);
    end

    dcheck("sub_min", 32'hffffffff, 32'h7fffffff, 4'd6, 32'h80000000, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_Z",    bus.Z, 32'd0);
    chk("async_zero", {31'd0, bus.zero}, 32'd1);
    chk("async_eq",   {31'd0, bus.equal}, 32'd0);
    chk("async_ovf",  {31'd0, bus.overflow}, 32'd0);
    $display("[TB] async reset asserted mid-cycle -> Z=%08h zero=%0b", bus.Z, bus.zero);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_Z",    bus.Z, 32'h80000000);
    chk("post_rst_ovf",  {31'd0, bus.overflow}, 32'd0);
    chk("post_rst_zero", {31'd0, bus.zero}, 32'd0);
    $display("[TB] first edge after release -> Z=%08h", bus.Z);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
